gray_step_tracker_4_bit: RTL and testbench
==========================================

Name: gray_step_tracker_4_bit

Overview:
- Sits directly downstream of the 4-bit binary-to-gray converter and consumes its Gray code stream, e.g. from a Gray-coded position source or a Gray-pointer interface.
- Registers each valid Gray sample and converts it to binary.
- Classifies each sample against the previous one as step up, step down, hold or illegal jump.
- Maintains a wrapping position count, an illegal-step count and a lock/fault state machine.

Parameters:
- POS_WIDTH, 8, width of Position_Out; position wraps modulo 2^POS_WIDTH.
- ERR_CNT_WIDTH, 8, width of Error_Count_Out; the count saturates at all-ones.
- ERR_LIMIT, 3, number of consecutive illegal steps in TRACK that forces FAULT; legal range 1..15.

Ports:
- Clock  input  1  single system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Gray_Valid_In  input  1  Gray_Code_In is sampled on this cycle.
- Gray_Code_In  input  4  Gray-coded sample.
- Resync_In  input  1  forces return to IDLE.
- Binary_Code_Out  output  4  binary value of the last accepted sample (registered).
- Binary_Valid_Out  output  1  one-cycle pulse, one cycle after Gray_Valid_In.
- Step_Up_Out  output  1  one-cycle pulse: legal +1 step.
- Step_Down_Out  output  1  one-cycle pulse: legal -1 step.
- Step_Error_Out  output  1  one-cycle pulse: illegal step.
- Position_Out  output  POS_WIDTH  accumulated position.
- Error_Count_Out  output  ERR_CNT_WIDTH  total illegal steps, saturating.
- Locked_Out  output  1  high in TRACK.
- Fault_Out  output  1  high in FAULT.

Behaviour:
- Reset: asynchronous, active-high; all outputs 0, state IDLE, reference register 0, consecutive-error counter 0. Asserting Reset mid-operation aborts everything immediately.
- Conversion:
  - B[3]=G[3]; B[2]=B[3]^G[2]; B[1]=B[2]^G[1]; B[0]=B[1]^G[0].
  - Binary_Code_Out/Binary_Valid_Out update on every valid sample in every state; latency 1 cycle.
- Step classification (TRACK only): d = (B_new - B_ref) mod 16.
  - d=0: hold; no pulse; counters unchanged.
  - d=1: up, including 15->0 wrap; Position +1; consecutive-error counter cleared.
  - d=15: down, including 0->15 wrap; Position -1; consecutive-error counter cleared.
  - Any other d: error; Step_Error_Out pulses; Error_Count_Out +1 (saturating); consecutive-error counter +1; Position unchanged.
  - B_ref <= B_new on every accepted sample, including errors.
- Position arithmetic: unsigned, wraps (all-ones +1 -> 0, 0 -1 -> all-ones).
- States:
  - IDLE: first valid sample loads B_ref, no step pulse; next state TRACK.
  - TRACK: classify as above. If the consecutive-error counter reaches ERR_LIMIT on this sample, next state is FAULT.
  - FAULT: samples are converted but not classified; no step pulses; Position and B_ref frozen.
- Resync_In (any state):
  - Next state IDLE; consecutive-error counter cleared.
  - Position_Out and Error_Count_Out are preserved.
  - Resync_In and Gray_Valid_In in the same cycle: resync wins for tracking (no classification, B_ref not loaded); conversion output still updates.
- Output timing:
  - Locked_Out=1 exactly while in TRACK; Fault_Out=1 exactly while in FAULT.
  - Step pulses, Position, counters and state all change on the edge after the sampling cycle.
- Step pulses are mutually exclusive; at most one is high per cycle.
- Gray_Valid_In=0: no state or counter changes; all pulses low.

Test Plan:
1. Reset with random inputs -> all outputs 0; release, no valid -> outputs stay 0, Locked_Out=0.
2. Valid Gray 0000,0001,0011,0010 on consecutive cycles:
   - Binary_Code_Out 0,1,2,3, each one cycle after its sample.
   - Locked_Out=1 after the first sample; three Step_Up pulses; Position_Out=3.
3. Wrap: from B_ref=15 (Gray 1000) feed 0000 -> Step_Up, Position +1. Feed 1000 again -> Step_Down, Position -1. With Position=0, a down step -> Position=255.
4. Fault path, ERR_LIMIT=3: in TRACK at Gray 0000, feed 0011, 0110, 1100 (B 2,4,8):
   - Three Step_Error pulses; Error_Count_Out=3.
   - Fault_Out=1 and Locked_Out=0 after the third error.
   - Further samples produce no step pulses.
   - Resync_In -> IDLE, Fault_Out=0, counts kept; next sample relocks.
5. Interleaved error then legal step -> consecutive counter cleared, no FAULT. Error_Count_Out saturation checked with ERR_CNT_WIDTH=2: stays at 3.
6. Resync_In and Gray_Valid_In together in TRACK -> Binary_Valid_Out pulses, no step pulse, state IDLE. Mid-sequence Reset -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/gray_step_tracker_4_bit.sv
// gray_step_tracker_4_bit: Gray-stream decoder with step classification, position tracking and lock/fault FSM
module gray_step_tracker_4_bit #(
    parameter int POS_WIDTH     = 8,
    parameter int ERR_CNT_WIDTH = 8,
    parameter int ERR_LIMIT     = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Gray_Valid_In,
    input  logic [3:0]               Gray_Code_In,
    input  logic                     Resync_In,
    output logic [3:0]               Binary_Code_Out,
    output logic                     Binary_Valid_Out,
    output logic                     Step_Up_Out,
    output logic                     Step_Down_Out,
    output logic                     Step_Error_Out,
    output logic [POS_WIDTH-1:0]     Position_Out,
    output logic [ERR_CNT_WIDTH-1:0] Error_Count_Out,
    output logic                     Locked_Out,
    output logic                     Fault_Out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;
    localparam logic [3:0] LIMIT = 4'(ERR_LIMIT);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] b_new;
    logic [3:0] b_ref;
    logic [3:0] delta;
    logic [3:0] cons_err;
    logic       classify;
    logic       is_up;
    logic       is_down;
    logic       is_err;
    logic       hit_limit;

    assign Locked_Out = (state == TRACK);
    assign Fault_Out  = (state == FAULT);

    // Decode the sample, classify it against the reference and pick the next state
    always_comb begin
        b_new[3]   = Gray_Code_In[3];
        b_new[2]   = b_new[3] ^ Gray_Code_In[2];
        b_new[1]   = b_new[2] ^ Gray_Code_In[1];
        b_new[0]   = b_new[1] ^ Gray_Code_In[0];
        delta      = b_new - b_ref;
        classify   = Gray_Valid_In && !Resync_In && (state == TRACK);
        is_up      = classify && (delta == 4'd1);
        is_down    = classify && (delta == 4'd15);
        is_err     = classify && (delta != 4'd0) && (delta != 4'd1) && (delta != 4'd15);
        hit_limit  = is_err && ((cons_err + 4'd1) >= LIMIT);
        state_next = Resync_In      ? IDLE  :
                     !Gray_Valid_In ? state :
                     state == IDLE  ? TRACK :
                     hit_limit      ? FAULT : state;
    end

    // Register conversion output, step pulses, counters and state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            b_ref            <= 4'd0;
            cons_err         <= 4'd0;
            Binary_Code_Out  <= 4'd0;
            Binary_Valid_Out <= 1'b0;
            Step_Up_Out      <= 1'b0;
            Step_Down_Out    <= 1'b0;
            Step_Error_Out   <= 1'b0;
            Position_Out     <= '0;
            Error_Count_Out  <= '0;
        end else begin
            state            <= state_next;
            Binary_Valid_Out <= Gray_Valid_In;
            Step_Up_Out      <= is_up;
            Step_Down_Out    <= is_down;
            Step_Error_Out   <= is_err;
            if (Gray_Valid_In)
                Binary_Code_Out <= b_new;
            if (Gray_Valid_In && !Resync_In && state != FAULT)
                b_ref <= b_new;
            cons_err <= Resync_In          ? 4'd0 :
                        is_err             ? cons_err + 4'd1 :
                        (is_up || is_down) ? 4'd0 : cons_err;
            Position_Out <= is_up   ? Position_Out + POS_WIDTH'(1) :
                            is_down ? Position_Out - POS_WIDTH'(1) : Position_Out;
            if (is_err && Error_Count_Out != ERR_MAX)
                Error_Count_Out <= Error_Count_Out + ERR_CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_gray_step_tracker_4_bit.sv
// tb_gray_step_tracker_4_bit: randomized and directed check against a behavioural tracker model
module tb_gray_step_tracker_4_bit;
    localparam int LIMIT = 3;

    logic       clk = 0;
    logic       rst = 0;
    logic       valid = 0;
    logic [3:0] gray = 0;
    logic       resync = 0;

    logic [3:0] bin;
    logic       bv, up, dn, er, locked, fault;
    logic [7:0] pos, errcnt;
    logic [3:0] bin2;
    logic       bv2, up2, dn2, er2, locked2, fault2;
    logic [7:0] pos2;
    logic [1:0] errcnt2;

    int checks = 0;
    int fails = 0;

    int m_state = 0, m_ref = 0, m_cons = 0, m_pos = 0, m_errs = 0;
    int e_bin = 0, e_bv = 0, e_up = 0, e_dn = 0, e_er = 0;

    gray_step_tracker_4_bit dut (
        .Clock(clk), .Reset(rst), .Gray_Valid_In(valid), .Gray_Code_In(gray), .Resync_In(resync),
        .Binary_Code_Out(bin), .Binary_Valid_Out(bv), .Step_Up_Out(up), .Step_Down_Out(dn),
        .Step_Error_Out(er), .Position_Out(pos), .Error_Count_Out(errcnt),
        .Locked_Out(locked), .Fault_Out(fault)
    );

    gray_step_tracker_4_bit #(.ERR_CNT_WIDTH(2)) dut2 (
        .Clock(clk), .Reset(rst), .Gray_Valid_In(valid), .Gray_Code_In(gray), .Resync_In(resync),
        .Binary_Code_Out(bin2), .Binary_Valid_Out(bv2), .Step_Up_Out(up2), .Step_Down_Out(dn2),
        .Step_Error_Out(er2), .Position_Out(pos2), .Error_Count_Out(errcnt2),
        .Locked_Out(locked2), .Fault_Out(fault2)
    );

    always #5 clk = ~clk;

    function automatic int g2b(input int g);
        for (int b = 0; b < 16; b++)
            if ((b ^ (b >> 1)) == g) return b;
        return 0;
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] g, input logic rs);
        valid = v;
        gray = g;
        resync = rs;
        @(posedge clk);
        #2;
    endtask

    // Reference tracker: states 0=idle 1=track 2=fault, step from modular difference
    always @(posedge clk or posedge rst) begin : model
        int b, d;
        if (rst) begin
            m_state <= 0; m_ref <= 0; m_cons <= 0; m_pos <= 0; m_errs <= 0;
            e_bin <= 0; e_bv <= 0; e_up <= 0; e_dn <= 0; e_er <= 0;
        end else begin
            b = g2b(int'(gray));
            d = (b - m_ref + 16) % 16;
            e_bv <= int'(valid);
            if (valid) e_bin <= b;
            e_up <= 0; e_dn <= 0; e_er <= 0;
            if (resync) begin
                m_state <= 0;
                m_cons <= 0;
            end else if (valid) begin
                if (m_state == 0) begin
                    m_ref <= b;
                    m_state <= 1;
                end else if (m_state == 1) begin
                    m_ref <= b;
                    if (d == 1) begin
                        e_up <= 1; m_pos <= (m_pos + 1) % 256; m_cons <= 0;
                    end else if (d == 15) begin
                        e_dn <= 1; m_pos <= (m_pos + 255) % 256; m_cons <= 0;
                    end else if (d != 0) begin
                        e_er <= 1; m_errs <= m_errs + 1; m_cons <= m_cons + 1;
                        if (m_cons + 1 >= LIMIT) m_state <= 2;
                    end
                end
            end
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        chk("bin", int'(bin), e_bin);
        chk("bin_valid", int'(bv), e_bv);
        chk("step_up", int'(up), e_up);
        chk("step_down", int'(dn), e_dn);
        chk("step_err", int'(er), e_er);
        chk("position", int'(pos), m_pos);
        chk("err_count", int'(errcnt), sat(m_errs, 255));
        chk("locked", int'(locked), int'(m_state == 1));
        chk("fault", int'(fault), int'(m_state == 2));
        chk("err_count_w2", int'(errcnt2), sat(m_errs, 3));
        chk("position_w2", int'(pos2), m_pos);
        chk("one_hot_pulses", int'(up) + int'(dn) + int'(er) <= 1 ? 1 : 0, 1);
    end

    initial begin
        int pb, k;
        #1 rst = 1;
        for (int i = 0; i < 4; i++) cyc(1'($urandom), 4'($urandom), 1'($urandom));
        chk("rst_bin", int'(bin), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_locked", int'(locked), 0);
        rst = 0;
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("idle_locked", int'(locked), 0);
        chk("idle_bv", int'(bv), 0);

        cyc(1, 4'b0000, 0);
        chk("t2_bin0", int'(bin), 0); chk("t2_locked", int'(locked), 1); chk("t2_noup", int'(up), 0);
        cyc(1, 4'b0001, 0);
        chk("t2_bin1", int'(bin), 1); chk("t2_up1", int'(up), 1);
        cyc(1, 4'b0011, 0);
        chk("t2_bin2", int'(bin), 2); chk("t2_up2", int'(up), 1);
        cyc(1, 4'b0010, 0);
        chk("t2_bin3", int'(bin), 3); chk("t2_pos3", int'(pos), 3); chk("model_pos3", m_pos, 3);
        cyc(0, 0, 0);
        chk("t2_bv_low", int'(bv), 0); chk("t2_hold_bin", int'(bin), 3);

        cyc(1, 4'b0000, 1);
        chk("t3_resync_locked", int'(locked), 0); chk("t3_resync_pos", int'(pos), 3);
        cyc(1, 4'b1000, 0);
        chk("t3_load15", int'(bin), 15); chk("t3_relock", int'(locked), 1); chk("t3_noup", int'(up), 0);
        cyc(1, 4'b0000, 0);
        chk("t3_wrap_up", int'(up), 1); chk("t3_pos4", int'(pos), 4);
        cyc(1, 4'b1000, 0);
        chk("t3_wrap_dn", int'(dn), 1); chk("t3_pos3", int'(pos), 3);
        rst = 1; cyc(0, 0, 0); rst = 0;
        cyc(1, 4'b0000, 0);
        cyc(1, 4'b1000, 0);
        chk("t3_pos255", int'(pos), 255); chk("model_pos255", m_pos, 255);

        cyc(1, 4'b0000, 0);
        chk("t4_pos0", int'(pos), 0);
        cyc(1, 4'b0011, 0);
        chk("t4_err1", int'(er), 1); chk("t4_cnt1", int'(errcnt), 1);
        cyc(1, 4'b0110, 0);
        chk("t4_cnt2", int'(errcnt), 2); chk("t4_still_locked", int'(locked), 1);
        cyc(1, 4'b1100, 0);
        chk("t4_cnt3", int'(errcnt), 3); chk("t4_fault", int'(fault), 1); chk("t4_unlocked", int'(locked), 0);
        cyc(1, 4'b1101, 0);
        chk("t4_fault_bin", int'(bin), 9); chk("t4_fault_noerr", int'(er), 0); chk("t4_fault_noup", int'(up), 0);
        cyc(0, 0, 1);
        chk("t4_resync_fault", int'(fault), 0); chk("t4_kept_cnt", int'(errcnt), 3); chk("t4_kept_pos", int'(pos), 0);
        cyc(1, 4'b0001, 0);
        chk("t4_relock", int'(locked), 1);

        cyc(1, 4'b0111, 0);
        chk("t5_cnt4", int'(errcnt), 4); chk("t5_sat", int'(errcnt2), 3);
        cyc(1, 4'b0101, 0);
        chk("t5_up", int'(up), 1);
        cyc(1, 4'b1111, 0);
        cyc(1, 4'b0000, 0);
        chk("t5_cnt6", int'(errcnt), 6); chk("t5_no_fault", int'(fault), 0);
        cyc(1, 4'b0001, 0);
        chk("t5_locked", int'(locked), 1); chk("t5_sat2", int'(errcnt2), 3);

        cyc(1, 4'b0011, 1);
        chk("t6_bv", int'(bv), 1); chk("t6_bin", int'(bin), 2); chk("t6_nostep", int'(up) | int'(er), 0);
        chk("t6_idle", int'(locked), 0);
        cyc(1, 4'b0011, 0);
        chk("t6_relock", int'(locked), 1);
        rst = 1;
        #1;
        chk("t6_async_pos", int'(pos), 0); chk("t6_async_cnt", int'(errcnt), 0);
        chk("t6_async_locked", int'(locked), 0); chk("t6_async_bv", int'(bv), 0);
        cyc(0, 0, 0);
        rst = 0;

        pb = 0;
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 9);
            pb = k < 4 ? (pb + 1) % 16 : k < 7 ? (pb + 15) % 16 : k == 7 ? pb : $urandom_range(0, 15);
            if ($urandom_range(0, 99) < 1) rst = 1;
            cyc(1'($urandom_range(0, 3) != 0), 4'(b2g(pb)), 1'($urandom_range(0, 39) == 0));
            rst = 0;
        end
        cyc(0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
